// File: rtl/dict_attack_seq_pkg.sv
// Shared definitions for the dictionary-attack sequencer: FSM states, status codes, LED codes.
package dict_attack_seq_pkg;

  typedef enum logic [3:0] {
    FSM_IDLE,
    FSM_LD_HASH,
    FSM_LD_KEY,
    FSM_RD_WORD,
    FSM_AES_REQ,
    FSM_AES_WAIT,
    FSM_CMP,
    FSM_SUCCESS,
    FSM_FAIL
  } fsm_e;

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_LOADING = 3'd1,
    ST_DICT    = 3'd2,
    ST_SUCCESS = 3'd3,
    ST_FAILURE = 3'd4
  } status_e;

  localparam logic [2:0] LED_RUN  = 3'b011;
  localparam logic [2:0] LED_OK   = 3'b010;
  localparam logic [2:0] LED_FAIL = 3'b001;

  function automatic status_e status_of(input fsm_e s);
    status_e st;
    case (s)
      FSM_LD_HASH, FSM_LD_KEY:                        st = ST_LOADING;
      FSM_RD_WORD, FSM_AES_REQ, FSM_AES_WAIT, FSM_CMP: st = ST_DICT;
      FSM_SUCCESS:                                     st = ST_SUCCESS;
      FSM_FAIL:                                        st = ST_FAILURE;
      default:                                         st = ST_WAIT;
    endcase
    return st;
  endfunction

  function automatic logic [2:0] led_of(input status_e st);
    logic [2:0] l;
    case (st)
      ST_SUCCESS: l = LED_OK;
      ST_FAILURE: l = LED_FAIL;
      default:    l = LED_RUN;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/dict_attack_seq_bram_rd_port.sv
// BRAM read port: holds address/enable and flags rd_valid once RD_LAT cycles have elapsed.
module dict_attack_seq_bram_rd_port #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              inc,
  input  logic              clr,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              rd_valid
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign rd_valid  = en_q && (cnt_q == CNT_W'(RD_LAT));
  assign bram_en   = en_q;
  assign bram_addr = addr_q;

  // Address is held after the read completes so the compare stage can still see it.
  always_comb begin
    en_d   = en_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (en_q && !rd_valid) cnt_d = cnt_q + 1'b1;
    if (rd_valid)          en_d  = 1'b0;
    if (clr) begin
      en_d   = 1'b0;
      addr_d = '0;
      cnt_d  = '0;
    end else if (ld) begin
      en_d   = 1'b1;
      addr_d = ld_addr;
      cnt_d  = '0;
    end else if (inc) begin
      en_d   = 1'b1;
      addr_d = addr_q + 1'b1;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/dict_attack_seq.sv
// Dictionary-attack sequencer: loads hash and key from BRAM, encrypts each dictionary
// entry on the shared encrypter and stops on the first entry whose ciphertext equals the hash.
module dict_attack_seq
  import dict_attack_seq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 128,
  parameter int HASH_ADDR   = 0,
  parameter int KEY_ADDR    = 1,
  parameter int DICT_START  = 3,
  parameter int DICT_SIZE   = 4,
  parameter int RD_LAT      = 1,
  parameter int AES_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] aes_data,
  output logic [DATA_W-1:0] aes_key,
  output logic              aes_decrypt,
  output logic              aes_start,
  input  logic              aes_done,
  input  logic [DATA_W-1:0] aes_result,
  output logic [2:0]        state,
  output logic [2:0]        led,
  output logic [ADDR_W-1:0] match_idx,
  output logic              timeout,
  output logic              busy
);

  localparam int                TO_W      = $clog2(AES_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DICT_START + DICT_SIZE - 1);

  if (DICT_SIZE > 0 && (DICT_START + DICT_SIZE - 1) >= (1 << ADDR_W)) begin : g_addr_chk
    $error("dict_attack_seq: dictionary end address does not fit in ADDR_W");
  end

  fsm_e              fsm_q, fsm_d;
  logic [DATA_W-1:0] hash_q, hash_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic [ADDR_W-1:0] match_q, match_d;
  logic              timeout_q, timeout_d;
  status_e           state_q, state_d;
  logic [2:0]        led_q, led_d;
  logic              busy_q, busy_d;

  logic              rp_ld, rp_inc, rp_clr, rd_valid;
  logic [ADDR_W-1:0] rp_addr;

  dict_attack_seq_bram_rd_port #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_rd_port (
    .clk       (clk),
    .reset     (reset),
    .ld        (rp_ld),
    .ld_addr   (rp_addr),
    .inc       (rp_inc),
    .clr       (rp_clr),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .rd_valid  (rd_valid)
  );

  assign aes_data    = data_q;
  assign aes_key     = key_q;
  assign aes_decrypt = 1'b0;
  assign state       = state_q;
  assign led         = led_q;
  assign match_idx   = match_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;

  always_comb begin
    fsm_d     = fsm_q;
    hash_d    = hash_q;
    key_d     = key_q;
    data_d    = data_q;
    res_d     = res_q;
    tcnt_d    = tcnt_q;
    match_d   = match_q;
    timeout_d = timeout_q;
    rp_ld     = 1'b0;
    rp_addr   = '0;
    rp_inc    = 1'b0;
    rp_clr    = 1'b0;
    aes_start = 1'b0;
    unique case (fsm_q)
      FSM_IDLE, FSM_SUCCESS, FSM_FAIL: begin
        if (start) begin
          fsm_d     = FSM_LD_HASH;
          rp_ld     = 1'b1;
          rp_addr   = ADDR_W'(HASH_ADDR);
          match_d   = '0;
          timeout_d = 1'b0;
        end
      end
      FSM_LD_HASH: begin
        if (rd_valid) begin
          hash_d  = bram_dout;
          rp_ld   = 1'b1;
          rp_addr = ADDR_W'(KEY_ADDR);
          fsm_d   = FSM_LD_KEY;
        end
      end
      FSM_LD_KEY: begin
        if (rd_valid) begin
          key_d = bram_dout;
          if (DICT_SIZE == 0) begin
            rp_clr = 1'b1;
            fsm_d  = FSM_FAIL;
          end else begin
            rp_ld   = 1'b1;
            rp_addr = ADDR_W'(DICT_START);
            fsm_d   = FSM_RD_WORD;
          end
        end
      end
      FSM_RD_WORD: begin
        if (rd_valid) begin
          data_d = bram_dout;
          fsm_d  = FSM_AES_REQ;
        end
      end
      FSM_AES_REQ: begin
        aes_start = 1'b1;
        tcnt_d    = TO_W'(1);  // counts cycles elapsed since the request pulse
        fsm_d     = FSM_AES_WAIT;
      end
      FSM_AES_WAIT: begin
        if (aes_done) begin
          res_d = aes_result;
          fsm_d = FSM_CMP;
        end else if (tcnt_q >= TO_W'(AES_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          rp_clr    = 1'b1;
          fsm_d     = FSM_FAIL;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      FSM_CMP: begin
        if (res_q == hash_q) begin
          match_d = bram_addr;
          rp_clr  = 1'b1;
          fsm_d   = FSM_SUCCESS;
        end else if (bram_addr == LAST_ADDR) begin
          rp_clr = 1'b1;
          fsm_d  = FSM_FAIL;
        end else begin
          rp_inc = 1'b1;
          fsm_d  = FSM_RD_WORD;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  always_comb begin
    state_d = status_of(fsm_q);
    led_d   = led_of(state_d);
    busy_d  = (state_d == ST_LOADING) || (state_d == ST_DICT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q     <= FSM_IDLE;
      hash_q    <= '0;
      key_q     <= '0;
      data_q    <= '0;
      res_q     <= '0;
      tcnt_q    <= '0;
      match_q   <= '0;
      timeout_q <= 1'b0;
      state_q   <= ST_WAIT;
      led_q     <= LED_RUN;
      busy_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      hash_q    <= hash_d;
      key_q     <= key_d;
      data_q    <= data_d;
      res_q     <= res_d;
      tcnt_q    <= tcnt_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
      state_q   <= state_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_dict_attack_seq.sv
// Scoreboard bench for dict_attack_seq: BRAM and encrypter models, reference run model, monitor.
module tb_dict_attack_seq;

  localparam int AW = 8, DW = 128, DS = 3, DN = 4, TO = 64;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, s0_start = 1'b0;
  logic          bram_en, aes_decrypt, aes_start, timeout, busy;
  logic [AW-1:0] bram_addr, match_idx;
  logic [DW-1:0] bram_dout, aes_data, aes_key;
  logic [DW-1:0] aes_result = '0;
  logic          aes_done = 1'b0;
  logic [2:0]    state, led;

  logic          s0_bram_en, s0_aes_decrypt, s0_aes_start, s0_timeout, s0_busy;
  logic [AW-1:0] s0_bram_addr, s0_match_idx;
  logic [DW-1:0] s0_bram_dout, s0_aes_data, s0_aes_key;
  logic [2:0]    s0_state, s0_led;

  always #5 clk = ~clk;

  dict_attack_seq #(.DICT_START(DS), .DICT_SIZE(DN), .RD_LAT(1), .AES_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .bram_en(bram_en), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .aes_data(aes_data), .aes_key(aes_key), .aes_decrypt(aes_decrypt),
    .aes_start(aes_start), .aes_done(aes_done), .aes_result(aes_result), .state(state),
    .led(led), .match_idx(match_idx), .timeout(timeout), .busy(busy));

  dict_attack_seq #(.DICT_START(DS), .DICT_SIZE(0), .RD_LAT(1), .AES_TIMEOUT(TO)) dut0 (
    .clk(clk), .reset(reset), .start(s0_start), .bram_en(s0_bram_en), .bram_addr(s0_bram_addr),
    .bram_dout(s0_bram_dout), .aes_data(s0_aes_data), .aes_key(s0_aes_key),
    .aes_decrypt(s0_aes_decrypt), .aes_start(s0_aes_start), .aes_done(1'b0), .aes_result('0),
    .state(s0_state), .led(s0_led), .match_idx(s0_match_idx), .timeout(s0_timeout),
    .busy(s0_busy));

  logic [DW-1:0] mem [0:255];
  always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];
  always @(posedge clk) if (s0_bram_en) s0_bram_dout <= mem[s0_bram_addr];

  // Stand-in cipher: rotate-left-by-one then xor key; invertible so matches can be planted.
  function automatic logic [DW-1:0] enc(input logic [DW-1:0] x, input logic [DW-1:0] k);
    return {x[DW-2:0], x[DW-1]} ^ k;
  endfunction
  function automatic logic [DW-1:0] dec(input logic [DW-1:0] h, input logic [DW-1:0] k);
    logic [DW-1:0] y;
    y = h ^ k;
    return {y[0], y[DW-1:1]};
  endfunction
  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]    st;
    logic [2:0]    led;
    logic [AW-1:0] idx;
    logic          to;
    int            pulses;
  } exp_t;
  exp_t sb[$];

  // Outcome of one run straight from the attack rules: first matching entry wins.
  function automatic exp_t ref_run(input bit hang_i);
    exp_t e;
    logic [DW-1:0] h, k;
    h = mem[0];
    k = mem[1];
    e.st = 3'd4; e.led = 3'b001; e.idx = '0; e.to = 1'b0; e.pulses = 0;
    for (int i = 0; i < DN; i++) begin
      e.pulses++;
      if (hang_i) begin
        e.to = 1'b1;
        break;
      end
      if (enc(mem[DS+i], k) == h) begin
        e.st = 3'd3; e.led = 3'b010; e.idx = AW'(DS + i);
        break;
      end
    end
    return e;
  endfunction

  // Encrypter model with programmable latency; abandons a request if reset hits.
  int lat = 10;
  bit hang = 1'b0;
  initial begin
    logic [DW-1:0] r;
    bit kill;
    forever begin
      @(posedge clk); #1;
      if (aes_start && !hang && !reset) begin
        r = enc(aes_data, aes_key);
        kill = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(posedge clk); #1;
          if (reset) kill = 1'b1;
        end
        if (!kill) begin
          aes_done = 1'b1; aes_result = r;
          @(posedge clk); #1;
          aes_done = 1'b0;
        end
      end
    end
  end

  int pulses = 0, s0_pulses = 0, done_cnt = 0, cyc = 0, last_start = 0, to_delta = -1;
  initial begin
    bit   prev_busy, prev_to;
    exp_t e;
    prev_busy = 1'b0;
    prev_to   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (s0_aes_start) s0_pulses++;
      if (reset) begin
        pulses = 0; prev_busy = 1'b0; prev_to = 1'b0;
      end else begin
        if (aes_start) begin pulses++; last_start = cyc; end
        if (timeout && !prev_to) to_delta = cyc - last_start;
        prev_to = timeout;
        if (prev_busy && !busy) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_completion: got state %0d want no run", state);
          end else begin
            e = sb.pop_front();
            chk("end_state", state, e.st);
            chk("end_led", led, e.led);
            chk("end_match_idx", match_idx, e.idx);
            chk("end_timeout", timeout, e.to);
            chk("aes_pulses", pulses, e.pulses);
            if (e.to) chk("timeout_cycles", to_delta, TO);
          end
          pulses = 0;
          done_cnt++;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic setup(input int pos);
    for (int i = 0; i < DN; i++) mem[DS+i] = rnd128();
    if (pos < DN) mem[DS+pos] = dec(mem[0], mem[1]);
  endtask

  task automatic run(input bit hang_i, input bit poke_busy, input bit exp_clear);
    int t0;
    hang = hang_i;
    sb.push_back(ref_run(hang_i));
    to_delta = -1;
    t0 = done_cnt;
    pulse_start();
    chk("first_addr", bram_addr, 0);
    chk("first_en", bram_en, 1);
    if (exp_clear) begin
      chk("rerun_match_idx_clear", match_idx, 0);
      chk("rerun_timeout_clear", timeout, 0);
    end
    if (poke_busy) begin
      repeat (8) @(posedge clk);
      pulse_start();
    end
    for (int i = 0; i < 3000 && done_cnt == t0; i++) @(posedge clk);
    if (done_cnt == t0) begin
      n_cmp++; n_bad++;
      $display("FAIL run_bound: got no completion want completion");
      void'(sb.pop_front());
    end
    repeat (2) @(posedge clk); #1;
    hang = 1'b0;
  endtask

  initial begin
    int t;
    for (int i = 0; i < 256; i++) mem[i] = rnd128();
    repeat (3) @(posedge clk); #1;
    chk("rst_state", state, 0);
    chk("rst_led", led, 3'b011);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_aes_start", aes_start, 0);
    chk("rst_aes_data", aes_data, 0);
    chk("rst_aes_key", aes_key, 0);
    chk("rst_match_idx", match_idx, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    setup(2);             // match at address 5
    run(0, 0, 0);
    run(0, 1, 1);         // rerun from SUCCESS with a stray start while busy
    setup(DN);            // no match
    run(0, 0, 0);
    run(1, 0, 0);         // encrypter hang
    mem[0] = rnd128(); mem[1] = rnd128();
    setup(0);
    run(0, 0, 1);         // rerun from timeout failure

    // Reset in AES_WAIT aborts at once and leaves no pending request.
    lat = 10;
    pulse_start();
    t = 0;
    while (!aes_start && t < 200) begin @(posedge clk); #1; t++; end
    chk("saw_aes_start", aes_start, 1);
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_led", led, 3'b011);
    chk("midrst_aes_start", aes_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_bram_en", bram_en, 0);
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("no_pulse_after_reset", pulses, 0);
    setup(3);
    run(0, 0, 0);

    for (int n = 0; n < 8; n++) begin
      lat = $urandom_range(1, 20);
      mem[0] = rnd128(); mem[1] = rnd128();
      setup($urandom_range(0, DN));
      if (n == 5) mem[DS+3] = mem[DS+1];  // duplicate entry: first one must win
      run(0, n[0], 0);
    end

    // Empty-dictionary build fails after the key load without touching the encrypter.
    s0_pulses = 0;
    @(posedge clk); #1 s0_start = 1'b1;
    @(posedge clk); #1 s0_start = 1'b0;
    t = 0;
    while (s0_state != 3'd4 && t < 100) begin @(posedge clk); #1; t++; end
    chk("dict0_state", s0_state, 4);
    chk("dict0_led", s0_led, 3'b001);
    chk("dict0_timeout", s0_timeout, 0);
    chk("dict0_busy", s0_busy, 0);
    chk("dict0_pulses", s0_pulses, 0);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
